// File: rtl/oled_frame_controller.sv
// SSD1331 PmodOLED controller: power-on, power-off, full-frame bitmap write
// and solid fill, with an integrated mode-3 SPI byte serialiser clocked by
// an enable derived from i_CLK.
module oled_frame_controller #(
    parameter int NUM_COL      = 96,
    parameter int NUM_ROW      = 64,
    parameter int N_COLOR_BITS = 8,
    parameter int SCLK_DIVIDER = 20,
    parameter int WAIT_3_US    = 300,
    parameter int WAIT_100_MS  = 10000000
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    input  logic [1:0]                   i_MODE,
    input  logic                         i_START,
    input  logic [N_COLOR_BITS-1:0]      i_TEXT_COLOR,
    input  logic [N_COLOR_BITS-1:0]      i_BACKGROUND_COLOR,
    input  logic [NUM_COL*NUM_ROW-1:0]   i_PIXEL,
    output logic                         o_READY,
    output logic                         o_DONE,
    output logic                         o_ERR,
    output logic                         o_CS,
    output logic                         o_MOSI,
    output logic                         o_SCK,
    output logic                         o_DC,
    output logic                         o_RES,
    output logic                         o_VCCEN,
    output logic                         o_PMODEN
);
    localparam int NPIX  = NUM_COL * NUM_ROW;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int H     = SCLK_DIVIDER / 2;
    localparam int HC_W  = (H > 1) ? $clog2(H) : 1;

    localparam logic [HC_W-1:0]  H_LAST    = HC_W'(H - 1);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(NPIX - 1);
    localparam logic [31:0]      W3_LAST   = 32'(WAIT_3_US - 1);
    localparam logic [31:0]      W100_LAST = 32'(WAIT_100_MS - 1);
    localparam bit               TWO_BYTES = (N_COLOR_BITS == 16);
    localparam logic [7:0]       REMAP_VAL = TWO_BYTES ? 8'h72 : 8'hA0;
    localparam logic [7:0]       COL_END   = 8'(NUM_COL - 1);
    localparam logic [7:0]       ROW_END   = 8'(NUM_ROW - 1);

    typedef enum logic [2:0] {
        SND_IDLE,
        SND_SETUP,
        SND_LOW,
        SND_HIGH,
        SND_TAIL
    } snd_state_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ON_RES_LOW,
        ST_ON_RES_HIGH,
        ST_ON_CMD,
        ST_ON_WAIT,
        ST_OFF_CMD,
        ST_OFF_WAIT,
        ST_ADDR_CMD,
        ST_PIXELS
    } state_t;

    // Serialiser state
    snd_state_t       snd_st_q;
    logic [HC_W-1:0]  hcnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             cs_q, sck_q, mosi_q, dc_q;

    // Sequencer state
    state_t           st_q;
    logic [31:0]      wcnt_q;
    logic [2:0]       byte_q;
    logic [PIX_W-1:0] pix_q;
    logic             lo_q, last_q;
    logic             fill_q, powered_q;
    logic [N_COLOR_BITS-1:0] text_q, bg_q;
    logic             ready_q, done_q, err_q, res_q, vccen_q, pmoden_q;

    // Sequencer <-> serialiser handshake
    logic             snd_start, snd_dc, snd_acc, snd_fin, snd_rise;
    logic [7:0]       snd_byte;
    logic [N_COLOR_BITS-1:0] pix_col;

    // Serialiser may take a new byte when idle or in the last CS-high cycle,
    // so consecutive bytes are exactly 18*H cycles apart.
    assign snd_fin  = (snd_st_q == SND_TAIL) && (hcnt_q == H_LAST);
    assign snd_rise = (snd_st_q == SND_HIGH) && (hcnt_q == H_LAST) && (bit_q == 3'd7);
    assign snd_acc  = snd_start && ((snd_st_q == SND_IDLE) || snd_fin);

    // Select the next byte to send from the sequencer state and counters
    always_comb begin
        snd_start = 1'b0;
        snd_dc    = 1'b0;
        snd_byte  = '0;
        pix_col   = (fill_q || !i_PIXEL[pix_q]) ? bg_q : text_q;
        case (st_q)
            ST_ON_CMD: begin
                snd_start = (byte_q < 3'd3);
                case (byte_q)
                    3'd0:    snd_byte = 8'hAF;
                    3'd1:    snd_byte = REMAP_VAL;
                    default: snd_byte = 8'h40;
                endcase
            end
            ST_OFF_CMD: begin
                snd_start = (byte_q == 3'd0);
                snd_byte  = 8'hAE;
            end
            ST_ADDR_CMD: begin
                snd_start = (byte_q < 3'd6);
                case (byte_q)
                    3'd0:    snd_byte = 8'h15;
                    3'd1:    snd_byte = 8'h00;
                    3'd2:    snd_byte = COL_END;
                    3'd3:    snd_byte = 8'h75;
                    3'd4:    snd_byte = 8'h00;
                    default: snd_byte = ROW_END;
                endcase
            end
            ST_PIXELS: begin
                snd_start = !last_q;
                snd_dc    = 1'b1;
                if (TWO_BYTES && !lo_q)
                    snd_byte = pix_col[N_COLOR_BITS-1 -: 8];
                else
                    snd_byte = pix_col[7:0];
            end
            default: ;
        endcase
    end

    // SPI mode-3 byte serialiser: setup H, 8 x (low H, high H), CS-high tail H
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            snd_st_q <= SND_IDLE;
            hcnt_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b1;
            mosi_q   <= 1'b0;
            dc_q     <= 1'b0;
        end else if (snd_acc) begin
            snd_st_q <= SND_SETUP;
            hcnt_q   <= '0;
            bit_q    <= '0;
            sh_q     <= snd_byte;
            cs_q     <= 1'b0;
            dc_q     <= snd_dc;
        end else begin
            case (snd_st_q)
                SND_SETUP: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_q   <= '0;
                        sck_q    <= 1'b0;
                        mosi_q   <= sh_q[7];
                        sh_q     <= {sh_q[6:0], 1'b0};
                        snd_st_q <= SND_LOW;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                SND_LOW: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_q   <= '0;
                        sck_q    <= 1'b1;
                        snd_st_q <= SND_HIGH;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                SND_HIGH: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            cs_q     <= 1'b1;
                            snd_st_q <= SND_TAIL;
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            sck_q    <= 1'b0;
                            mosi_q   <= sh_q[7];
                            sh_q     <= {sh_q[6:0], 1'b0};
                            snd_st_q <= SND_LOW;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                SND_TAIL: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_q   <= '0;
                        snd_st_q <= SND_IDLE;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command sequencer with registered status and power/reset pins.
    // Command states exit on the last byte's CS rise; the trailing CS-high
    // time overlaps the following wait or the next byte's acceptance.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            st_q      <= ST_IDLE;
            wcnt_q    <= '0;
            byte_q    <= '0;
            pix_q     <= '0;
            lo_q      <= 1'b0;
            last_q    <= 1'b0;
            fill_q    <= 1'b0;
            powered_q <= 1'b0;
            text_q    <= '0;
            bg_q      <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            res_q     <= 1'b1;
            vccen_q   <= 1'b0;
            pmoden_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (i_START && ready_q) begin
                        if (i_MODE[1] && !powered_q) begin
                            err_q <= 1'b1;
                        end else begin
                            ready_q <= 1'b0;
                            fill_q  <= i_MODE[0];
                            text_q  <= i_TEXT_COLOR;
                            bg_q    <= i_BACKGROUND_COLOR;
                            byte_q  <= '0;
                            pix_q   <= '0;
                            lo_q    <= 1'b0;
                            last_q  <= 1'b0;
                            wcnt_q  <= '0;
                            case (i_MODE)
                                2'b00: begin
                                    res_q <= 1'b0;
                                    st_q  <= ST_ON_RES_LOW;
                                end
                                2'b01: begin
                                    if (powered_q) begin
                                        st_q <= ST_OFF_CMD;
                                    end else begin
                                        vccen_q <= 1'b0;
                                        st_q    <= ST_OFF_WAIT;
                                    end
                                end
                                default: st_q <= ST_ADDR_CMD;
                            endcase
                        end
                    end
                end
                ST_ON_RES_LOW: begin
                    if (wcnt_q == W3_LAST) begin
                        wcnt_q   <= '0;
                        res_q    <= 1'b1;
                        pmoden_q <= 1'b1;
                        vccen_q  <= 1'b1;
                        st_q     <= ST_ON_RES_HIGH;
                    end else begin
                        wcnt_q <= wcnt_q + 32'd1;
                    end
                end
                ST_ON_RES_HIGH: begin
                    if (wcnt_q == W3_LAST) begin
                        wcnt_q <= '0;
                        st_q   <= ST_ON_CMD;
                    end else begin
                        wcnt_q <= wcnt_q + 32'd1;
                    end
                end
                ST_ON_CMD: begin
                    if (snd_acc)
                        byte_q <= byte_q + 3'd1;
                    if (byte_q == 3'd3 && snd_rise)
                        st_q <= ST_ON_WAIT;
                end
                ST_ON_WAIT: begin
                    if (wcnt_q == W100_LAST) begin
                        wcnt_q    <= '0;
                        powered_q <= 1'b1;
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        st_q      <= ST_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 32'd1;
                    end
                end
                ST_OFF_CMD: begin
                    if (snd_acc)
                        byte_q <= byte_q + 3'd1;
                    if (byte_q == 3'd1 && snd_rise) begin
                        vccen_q <= 1'b0;
                        st_q    <= ST_OFF_WAIT;
                    end
                end
                ST_OFF_WAIT: begin
                    if (wcnt_q == W100_LAST) begin
                        wcnt_q    <= '0;
                        pmoden_q  <= 1'b0;
                        powered_q <= 1'b0;
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        st_q      <= ST_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 32'd1;
                    end
                end
                ST_ADDR_CMD: begin
                    if (snd_acc)
                        byte_q <= byte_q + 3'd1;
                    if (byte_q == 3'd6 && snd_rise)
                        st_q <= ST_PIXELS;
                end
                ST_PIXELS: begin
                    if (snd_acc) begin
                        if (TWO_BYTES && !lo_q) begin
                            lo_q <= 1'b1;
                        end else begin
                            lo_q <= 1'b0;
                            if (pix_q == PIX_LAST)
                                last_q <= 1'b1;
                            else
                                pix_q <= pix_q + 1'b1;
                        end
                    end
                    if (last_q && snd_rise) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        st_q    <= ST_IDLE;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign o_READY  = ready_q;
    assign o_DONE   = done_q;
    assign o_ERR    = err_q;
    assign o_CS     = cs_q;
    assign o_SCK    = sck_q;
    assign o_MOSI   = mosi_q;
    assign o_DC     = dc_q;
    assign o_RES    = res_q;
    assign o_VCCEN  = vccen_q;
    assign o_PMODEN = pmoden_q;

endmodule

// File: tb/tb_oled_frame_controller.sv
// Scoreboard bench: directed requests push expected SPI bytes; a monitor
// decodes the SPI pins and pops/compares on each completed byte.
module tb_oled_frame_controller;
    localparam int NC = 4, NR = 2, SD = 4, W3 = 5, W100 = 50;
    localparam int H = SD / 2, NP = NC * NR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    [2];
    logic [1:0]    mode   [2];
    logic          start  [2];
    logic [NP-1:0] pix    [2];
    logic [7:0]    text8, bg8;
    logic [15:0]   text16, bg16;
    logic ready[2], done[2], err[2], cs[2], mosi[2], sck[2], dc[2], res[2], vccen[2], pmoden[2];

    oled_frame_controller #(
        .NUM_COL(NC), .NUM_ROW(NR), .N_COLOR_BITS(8),
        .SCLK_DIVIDER(SD), .WAIT_3_US(W3), .WAIT_100_MS(W100)
    ) dut8 (
        .i_CLK(clk), .i_RST(rst[0]), .i_MODE(mode[0]), .i_START(start[0]),
        .i_TEXT_COLOR(text8), .i_BACKGROUND_COLOR(bg8), .i_PIXEL(pix[0]),
        .o_READY(ready[0]), .o_DONE(done[0]), .o_ERR(err[0]), .o_CS(cs[0]),
        .o_MOSI(mosi[0]), .o_SCK(sck[0]), .o_DC(dc[0]), .o_RES(res[0]),
        .o_VCCEN(vccen[0]), .o_PMODEN(pmoden[0])
    );

    oled_frame_controller #(
        .NUM_COL(NC), .NUM_ROW(NR), .N_COLOR_BITS(16),
        .SCLK_DIVIDER(SD), .WAIT_3_US(W3), .WAIT_100_MS(W100)
    ) dut16 (
        .i_CLK(clk), .i_RST(rst[1]), .i_MODE(mode[1]), .i_START(start[1]),
        .i_TEXT_COLOR(text16), .i_BACKGROUND_COLOR(bg16), .i_PIXEL(pix[1]),
        .o_READY(ready[1]), .o_DONE(done[1]), .o_ERR(err[1]), .o_CS(cs[1]),
        .o_MOSI(mosi[1]), .o_SCK(sck[1]), .o_DC(dc[1]), .o_RES(res[1]),
        .o_VCCEN(vccen[1]), .o_PMODEN(pmoden[1])
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    logic [8:0] expq0[$];
    logic [8:0] expq1[$];

    task automatic push(input int d, input logic dcb, input logic [7:0] b);
        if (d == 0) expq0.push_back({dcb, b});
        else        expq1.push_back({dcb, b});
    endtask

    // SPI monitor / scoreboard consumer
    logic       pcs [2] = '{1'b1, 1'b1};
    logic       psck[2] = '{1'b1, 1'b1};
    logic       dcv [2];
    logic [7:0] shv [2];
    int nbits[2], tfall[2];
    int tlastfall[2] = '{-1, -1};
    int trise[2]     = '{0, 0};
    int ncsf[2]      = '{0, 0};
    int nerr[2]      = '{0, 0};

    always @(negedge clk) begin
        logic [8:0] e;
        bit has;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                tlastfall[d] = -1;
            end else begin
                if (err[d]) nerr[d]++;
                if (pcs[d] && !cs[d]) begin
                    ncsf[d]++;
                    if (tlastfall[d] >= 0 && (cyc - tlastfall[d]) < 60)
                        check("byte_period", cyc - tlastfall[d], 18 * H);
                    tlastfall[d] = cyc;
                    tfall[d] = cyc;
                    nbits[d] = 0;
                    dcv[d] = dc[d];
                end
                if (!cs[d] && !psck[d] && sck[d]) begin
                    shv[d] = {shv[d][6:0], mosi[d]};
                    nbits[d]++;
                end
                if (!pcs[d] && cs[d]) begin
                    trise[d] = cyc;
                    check("bit_count", nbits[d], 8);
                    check("cs_low_len", cyc - tfall[d], 17 * H);
                    has = 1'b0;
                    e = '0;
                    if (d == 0) begin
                        if (expq0.size() > 0) begin has = 1'b1; e = expq0.pop_front(); end
                    end else begin
                        if (expq1.size() > 0) begin has = 1'b1; e = expq1.pop_front(); end
                    end
                    if (!has) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spi_unexpected: dut%0d got dc=%0b byte=%02h, required no byte", d, dcv[d], shv[d]);
                    end else begin
                        check("spi_byte", {dcv[d], shv[d]}, e);
                    end
                end
            end
            pcs[d]  = cs[d];
            psck[d] = sck[d];
        end
    end

    function automatic logic [9:0] pins(input int d);
        return {ready[d], done[d], err[d], cs[d], sck[d], mosi[d], dc[d], res[d], vccen[d], pmoden[d]};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int d, input logic [1:0] m);
        mode[d]  = m;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output int t);
        int n;
        n = 0;
        t = -1;
        while (n < budget && t < 0) begin
            if (done[d]) t = cyc;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("done_seen", (t >= 0) ? 1 : 0, 1);
        if (t >= 0) check("ready_with_done", ready[d], 1);
    endtask

    task automatic power_on(input int d, input logic [7:0] remap);
        int n, t;
        push(d, 1'b0, 8'hAF);
        push(d, 1'b0, remap);
        push(d, 1'b0, 8'h40);
        issue(d, 2'b00);
        check("on_ready_low", ready[d], 0);
        n = 0;
        while (res[d] == 1'b0 && n < 20) begin
            n++;
            tick(1);
        end
        check("res_low_cycles", n, W3);
        check("on_pmoden", pmoden[d], 1);
        check("on_vccen", vccen[d], 1);
        wait_done(d, 400, t);
        check("done_after_cs_rise", t - trise[d], W100);
        tick(1);
        check("done_one_cycle", done[d], 0);
    endtask

    initial begin
        int t, n, tv, tp, e0, c0;
        logic [7:0] frame_bytes [8];

        rst[0] = 1'b1; rst[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        mode[0] = 2'b00; mode[1] = 2'b00;
        pix[0] = '0; pix[1] = '0;
        text8 = '0; bg8 = '0; text16 = '0; bg16 = '0;

        // Reset holds pins regardless of input activity
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start[0] = 1'b1; start[1] = 1'b1;
            mode[0] = 2'(i); mode[1] = 2'(3 - i);
            pix[0] = 8'(i * 37);
        end
        check("reset_pins_dut8", pins(0), 10'b0001100100);
        check("reset_pins_dut16", pins(1), 10'b0001100100);
        rst[0] = 1'b0; rst[1] = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        check("ready_during_release", ready[0], 0);
        tick(1);
        check("ready_after_release_8", ready[0], 1);
        check("ready_after_release_16", ready[1], 1);

        // Fill before power-on is rejected with no pin activity
        c0 = ncsf[0];
        issue(0, 2'b11);
        check("err_unpowered_fill", err[0], 1);
        check("err_ready_stays", ready[0], 1);
        tick(1);
        check("err_one_cycle", err[0], 0);
        tick(40);
        check("err_no_cs_activity", ncsf[0] - c0, 0);

        power_on(0, 8'hA0);

        // Frame write: bit index = row*NC + col, index 0 sent first
        pix[0] = 8'b1010_0101;
        text8 = 8'hFF;
        bg8 = 8'h03;
        frame_bytes = '{8'hFF, 8'h03, 8'hFF, 8'h03, 8'h03, 8'hFF, 8'h03, 8'hFF};
        push(0, 1'b0, 8'h15); push(0, 1'b0, 8'h00); push(0, 1'b0, 8'h03);
        push(0, 1'b0, 8'h75); push(0, 1'b0, 8'h00); push(0, 1'b0, 8'h01);
        for (int i = 0; i < 8; i++) push(0, 1'b1, frame_bytes[i]);
        issue(0, 2'b10);
        check("frame_ready_low", ready[0], 0);
        wait_done(0, 800, t);
        tick(4);
        check("frame_queue_drained", expq0.size(), 0);

        // 16-bit fill on the second instance
        power_on(1, 8'h72);
        bg16 = 16'hF800;
        text16 = 16'h1234;
        pix[1] = 8'hFF;
        push(1, 1'b0, 8'h15); push(1, 1'b0, 8'h00); push(1, 1'b0, 8'h03);
        push(1, 1'b0, 8'h75); push(1, 1'b0, 8'h00); push(1, 1'b0, 8'h01);
        for (int i = 0; i < NP; i++) begin
            push(1, 1'b1, 8'hF8);
            push(1, 1'b1, 8'h00);
        end
        issue(1, 2'b11);
        wait_done(1, 1200, t);
        tick(4);
        check("fill16_queue_drained", expq1.size(), 0);

        // Power-off with ignored start while busy
        e0 = nerr[0];
        c0 = ncsf[0];
        push(0, 1'b0, 8'hAE);
        issue(0, 2'b01);
        tick(3);
        mode[0] = 2'b10;
        start[0] = 1'b1;
        tick(3);
        start[0] = 1'b0;
        n = 0;
        while (vccen[0] == 1'b1 && n < 200) begin n++; tick(1); end
        tv = cyc;
        check("off_vccen_fell", vccen[0], 0);
        check("off_pmoden_still_on", pmoden[0], 1);
        n = 0;
        while (pmoden[0] == 1'b1 && n < 200) begin n++; tick(1); end
        tp = cyc;
        check("off_pmoden_delay", tp - tv, W100);
        check("off_done_with_pmoden", done[0], 1);
        tick(4);
        check("off_busy_start_no_err", nerr[0] - e0, 0);
        check("off_single_byte", ncsf[0] - c0, 1);
        check("off_queue_drained", expq0.size(), 0);
        issue(0, 2'b10);
        check("err_after_poweroff", err[0], 1);
        tick(2);

        // Mid-frame reset abort
        power_on(0, 8'hA0);
        push(0, 1'b0, 8'h15); push(0, 1'b0, 8'h00); push(0, 1'b0, 8'h03);
        push(0, 1'b0, 8'h75); push(0, 1'b0, 8'h00); push(0, 1'b0, 8'h01);
        for (int i = 0; i < 8; i++) push(0, 1'b1, frame_bytes[i]);
        issue(0, 2'b10);
        tick(9 * 18 * H + 7);
        check("abort_mid_frame", (expq0.size() > 0) ? 1 : 0, 1);
        check("abort_cs_low_before", cs[0], 0);
        rst[0] = 1'b1;
        #1;
        check("abort_cs", cs[0], 1);
        check("abort_sck", sck[0], 1);
        check("abort_pmoden", pmoden[0], 0);
        check("abort_ready", ready[0], 0);
        tick(2);
        rst[0] = 1'b0;
        expq0.delete();
        tick(1);
        check("abort_ready_back", ready[0], 1);
        issue(0, 2'b10);
        check("err_after_abort", err[0], 1);
        tick(40);
        check("final_queue0_empty", expq0.size(), 0);
        check("final_queue1_empty", expq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/oled_frame_controller.md
Name: oled_frame_controller

Overview:
- Single-clock SSD1331 PmodOLED controller with four modes: power-on, power-off, full-frame bitmap write and solid fill.
- Contains its own SPI byte serialiser (mode 3, MSB first) driven by a clock-enable from i_CLK; no derived clocks.
- Sits between user logic (text/graphics engine) and the OLED pins; extends the earlier turn-on/single-pixel controller with frame streaming, power-off, 16-bit colour and status handshake.

Parameters:
- NUM_COL, 96, display columns
- NUM_ROW, 64, display rows
- N_COLOR_BITS, 8, bits per pixel; legal values 8 (one byte per pixel) or 16 (two bytes per pixel, MSB byte first)
- SCLK_DIVIDER, 20, i_CLK cycles per SCK period; even, >=2; half-period H = SCLK_DIVIDER/2
- WAIT_3_US, 300, i_CLK cycles per reset-pulse/settle wait
- WAIT_100_MS, 10000000, i_CLK cycles per power-rail settle wait

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  reset; asynchronous, active-high
- i_MODE  in  2  00 power-on, 01 power-off, 10 frame write, 11 fill
- i_START  in  1  request; sampled only while o_READY=1
- i_TEXT_COLOR  in  N_COLOR_BITS  colour for pixel bit 1
- i_BACKGROUND_COLOR  in  N_COLOR_BITS  colour for pixel bit 0 and for fill
- i_PIXEL  in  NUM_COL*NUM_ROW  bitmap; bit index = row*NUM_COL+col
- o_READY  out  1  idle, accepts i_START
- o_DONE  out  1  one-cycle pulse at command completion
- o_ERR  out  1  one-cycle pulse on rejected request
- o_CS, o_MOSI, o_SCK, o_DC  out  1 each  SPI to OLED
- o_RES  out  1  OLED reset, active low
- o_VCCEN  out  1  panel VCC enable
- o_PMODEN  out  1  VDD logic enable

Behaviour:
- Reset values: o_READY=0, o_DONE=0, o_ERR=0, o_CS=1, o_SCK=1, o_MOSI=0, o_DC=0, o_RES=1, o_VCCEN=0, o_PMODEN=0. FSM returns to IDLE. An internal powered flag clears. Reset asserted mid-operation aborts immediately; pins go to reset values.
- IDLE: o_READY=1 from the first cycle after reset release. i_START=1 with o_READY=1 is accepted on that edge: o_READY=0 next cycle, and the mode and both colours are latched. i_PIXEL is not latched and must stay stable while o_READY=0.
- Request rejection: modes 10 or 11 while the powered flag is 0 produce o_ERR=1 for one cycle. No pin activity occurs and o_READY stays 1.
- Byte sender, per byte:
  - CS falls, DC is set, wait H.
  - 8 bits MSB first: SCK low for H cycles with MOSI updated on the SCK falling edge, then SCK high for H cycles.
  - CS high for H cycles.
  - One byte = 18*H i_CLK cycles. DC: 0 = command, 1 = data.
- Power-on sequence (mode 00):
  - ON_RES_LOW: o_RES=0 for WAIT_3_US cycles.
  - ON_RES_HIGH: o_RES=1, o_PMODEN=1, o_VCCEN=1, hold WAIT_3_US cycles.
  - ON_CMD: send commands AF, A0, 40 (A0 value 72 when N_COLOR_BITS=16).
  - ON_WAIT: WAIT_100_MS cycles.
  - Set the powered flag, then DONE.
  - Re-issuing mode 00 while powered is legal and reruns the full sequence.
- Power-off sequence (mode 01):
  - OFF_CMD: send AE (skipped if not powered).
  - o_VCCEN=0, wait WAIT_100_MS.
  - o_PMODEN=0, clear the powered flag, then DONE.
- Frame/fill sequence (modes 10/11):
  - ADDR_CMD: send 15, 00, NUM_COL-1, 75, 00, NUM_ROW-1 as commands.
  - PIXELS: pixel counter 0..NUM_COL*NUM_ROW-1, row-major. Colour = i_PIXEL[idx] ? text : background in mode 10; always background in mode 11. Each pixel sends N_COLOR_BITS/8 data bytes.
  - Counter width is clog2(NUM_COL*NUM_ROW). There is no wrap; the last pixel leads to DONE.
- DONE: o_DONE=1 for one cycle, with o_READY=1 in the same cycle. A new i_START is accepted from the next cycle.
- Wait counters are 32-bit, count 0..WAIT-1, and clear on state exit.
- i_START while busy is ignored (not queued).

Test Plan:
- Bench parameters: NUM_COL=4, NUM_ROW=2, SCLK_DIVIDER=4, WAIT_3_US=5, WAIT_100_MS=50.
- Reset: hold i_RST, toggle inputs -> all outputs at reset values. Release -> o_READY=1 next cycle.
- Power-on: mode 00 -> o_RES low for exactly 5 cycles, then PMODEN/VCCEN=1. SPI monitor decodes AF, A0, 40 with DC=0 and each byte 36 cycles. o_DONE pulses 50 cycles after the last CS rise.
- Frame: after power-on, mode 10, i_PIXEL=8'b1010_0101, text=FF, background=03 -> commands 15 00 03 75 00 01, then data FF 03 FF 03 03 FF 03 FF (index 0 first), then o_DONE.
- Fill, 16-bit: N_COLOR_BITS=16, background=F800 -> 8 pixel pairs F8,00 with DC=1.
- Errors/abort: mode 11 before power-on -> o_ERR pulse, no CS activity. Mid-frame i_RST pulse -> CS=1, SCK=1, PMODEN=0 immediately; a later mode 10 -> o_ERR.
- Power-off: after power-on, mode 01 -> AE sent, VCCEN falls, PMODEN falls 50 cycles later, o_DONE. i_START during busy -> no effect.
